mem_stage_sram: RTL and testbench
=================================

// Module: mem_stage_sram
// PURPOSE
//  Memory stage of the ARM pipeline, between the EXE stage register and mem_stage_reg.
//  Turns a 32-bit load/store into two 16-bit accesses on an external asynchronous SRAM.
//  Freezes the pipeline until the access completes, then presents load data on Mem_Out.
//  Mem_Out feeds the Mem input of mem_stage_reg; Freeze_Out drives its freeze input and those of the upstream stages.
// PARAMETERS
//  ADDR_W      18    SRAM half-word address width
//  WAIT_CYCLES 1     extra cycles each half-word phase is held; phase length = WAIT_CYCLES+1
//  BASE_ADDR   1024  byte address subtracted from ALU_Result before SRAM mapping
// PORTS
//  clk         in    1       pipeline clock, rising edge
//  rst         in    1       asynchronous, active-high reset
//  MEM_R_EN    in    1       load request (held by the pipeline while frozen)
//  MEM_W_EN    in    1       store request (held by the pipeline while frozen)
//  ALU_Result  in    32      byte address
//  Val_Rm      in    32      store data
//  Mem_Out     out   32      registered load data
//  ready       out   1       access complete / no access pending
//  Freeze_Out  out   1       (MEM_R_EN|MEM_W_EN) & ~ready
//  SRAM_ADDR   out   ADDR_W  SRAM half-word address
//  SRAM_DQ     inout 16      SRAM data bus
//  SRAM_WE_N   out   1       SRAM write enable, active low
// BEHAVIOUR
//  Address mapping:
//   - off = ALU_Result - BASE_ADDR, 32-bit wrap.
//   - word = off[ADDR_W:2]; ALU_Result[1:0] ignored unless the macro is defined.
//   - SRAM_ADDR = {word,1'b0} in LOW, {word,1'b1} in HIGH, 0 otherwise.
//  FSM states: IDLE, LOW, HIGH, DONE; a phase counter counts 0..WAIT_CYCLES.
//   - IDLE: a request present -> LOW with counter=0. If both enables are high, the write wins.
//   - LOW: counter increments; at WAIT_CYCLES -> HIGH, counter cleared.
//     On a read, Val_Rm-independent capture: SRAM_DQ -> data_lo on that last LOW cycle.
//   - HIGH: same as LOW. At WAIT_CYCLES -> DONE.
//     On a read, Mem_Out <= {SRAM_DQ, data_lo} on that last HIGH cycle.
//   - DONE: exactly one cycle with ready=1, then unconditionally back to IDLE.
//     The next instruction is sampled in IDLE.
//  ready = (state==DONE) | (state==IDLE & ~MEM_R_EN & ~MEM_W_EN).
//  Latency: request seen in IDLE at cycle 0 -> DONE at cycle 2*(WAIT_CYCLES+1)+1.
//   - WAIT_CYCLES=1: ready rises in cycle 5; Freeze_Out is high in cycles 0-4.
//  Writes:
//   - SRAM_WE_N=0 throughout LOW and HIGH.
//   - SRAM_DQ driven with Val_Rm[15:0] in LOW and Val_Rm[31:16] in HIGH.
//   - Mem_Out is unchanged by a write.
//  SRAM_DQ is hi-Z in every state except during a write. SRAM_WE_N=1 at all other times.
//  Mem_Out holds its value until the next read completes.
//  Enables dropping mid-access (flush) do not abort the access; it runs to DONE.
//  Reset values (also on reset mid-access):
//   - state=IDLE, counter=0, data_lo=0, Mem_Out=0.
//   - SRAM_WE_N=1, SRAM_DQ hi-Z, SRAM_ADDR=0.
//   - ready/Freeze_Out follow the request inputs from IDLE.
//   - A write in progress is cut off immediately; the SRAM content is undefined for that word.
// CONFIGURATION
//  MEM_STAGE_ALIGN_CHECK_EN defined:
//   - Adds output Align_Err (1 bit, reset 0).
//   - Misaligned request (ALU_Result[1:0]!=0) in IDLE -> DONE next cycle.
//   - No SRAM access; SRAM_WE_N stays 1.
//   - Align_Err=1 only in that DONE cycle; a misaligned read loads Mem_Out=0.
//  Not defined: no Align_Err port; low address bits ignored; all accesses take the full sequence.
// TESTING
//  Store ALU_Result=1024, Val_Rm=32'hDEADBEEF (WAIT_CYCLES=1):
//   -> SRAM_ADDR 0 with DQ=BEEF for 2 cycles, then ADDR 1 with DQ=DEAD for 2 cycles, WE_N low both phases.
//   -> ready high in cycle 5.
//  Load from 1024 after that store (SRAM model) -> Mem_Out=32'hDEADBEEF in the DONE cycle.
//   -> Freeze_Out high cycles 0-4; DQ never driven by the DUT.
//  Back-to-back load at 1028 then store at 1032:
//   -> SRAM_ADDR 2,3 then 4,5; exactly one DONE cycle between the two accesses; no overlap.
//  Both MEM_R_EN and MEM_W_EN high -> write sequence executes; Mem_Out unchanged.
//  rst asserted in the middle of the HIGH phase of a write:
//   -> immediate IDLE, WE_N=1, DQ hi-Z, Mem_Out=0.
//   -> A new load after reset completes normally.
//  Align macro on, load at 1026 -> DONE next cycle, Align_Err=1 for one cycle, Mem_Out=0, no SRAM activity.

Source files
------------

// File: rtl/mem_stage_sram.sv
// Memory stage: turns a 32-bit load/store into two 16-bit accesses on an async SRAM.
// Latency: 2*(WAIT_CYCLES+1)+1 cycles from request in IDLE to the single ready (DONE) cycle.
// Backpressure: Freeze_Out holds the pipeline while a request is pending; optional MEM_STAGE_ALIGN_CHECK_EN.
module mem_stage_sram #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_Result,
    input  logic [31:0]       Val_Rm,
    output logic [31:0]       Mem_Out,
    output logic              ready,
    output logic              Freeze_Out,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]       SRAM_DQ,
    output logic              SRAM_WE_N
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    ,
    output logic              Align_Err
`endif
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic [ADDR_W-2:0] word_q, word_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [15:0]       data_lo_q, data_lo_d;
    logic [31:0]       mem_out_q, mem_out_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic              sram_we_n_q, sram_we_n_d;
    logic [15:0]       dq_out_q, dq_out_d;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic              align_err_q, align_err_d;
`endif

    logic [31:0] off;
    logic        req;
    logic        last;
    logic        unused_off;

    assign off        = ALU_Result - 32'(BASE_ADDR);
    assign req        = MEM_R_EN | MEM_W_EN;
    assign last       = (cnt_q == CNT_MAX);
    assign unused_off = ^{off[31:ADDR_W+1], off[1:0]};

    // Next-state logic; SRAM pins are computed from the next state so they come straight off flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        word_d    = word_q;
        wdat_d    = wdat_q;
        data_lo_d = data_lo_q;
        mem_out_d = mem_out_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        align_err_d = align_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    // write wins when both enables are set
                    is_wr_d = MEM_W_EN;
                    word_d  = off[ADDR_W:2];
                    wdat_d  = Val_Rm;
                    cnt_d   = '0;
                    state_d = S_LOW;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                    if (ALU_Result[1:0] != 2'b00) begin
                        state_d     = S_DONE;
                        is_wr_d     = 1'b0;
                        align_err_d = 1'b1;
                        if (!MEM_W_EN) mem_out_d = '0;
                    end
`endif
                end
            end
            S_LOW: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                    if (!is_wr_q) data_lo_d = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (!is_wr_q) mem_out_d = {SRAM_DQ, data_lo_q};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // DONE lasts exactly one cycle; a flush never aborts an access
                state_d = S_IDLE;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                align_err_d = 1'b0;
`endif
            end
        endcase

        sram_addr_d = '0;
        if (state_d == S_LOW)  sram_addr_d = {word_d, 1'b0};
        if (state_d == S_HIGH) sram_addr_d = {word_d, 1'b1};
        sram_we_n_d = ~(is_wr_d & ((state_d == S_LOW) | (state_d == S_HIGH)));
        dq_out_d    = (state_d == S_HIGH) ? wdat_d[31:16] : wdat_d[15:0];
    end

    // State and registered outputs; reset cuts any write off immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            word_q      <= '0;
            wdat_q      <= '0;
            data_lo_q   <= '0;
            mem_out_q   <= '0;
            sram_addr_q <= '0;
            sram_we_n_q <= 1'b1;
            dq_out_q    <= '0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            word_q      <= word_d;
            wdat_q      <= wdat_d;
            data_lo_q   <= data_lo_d;
            mem_out_q   <= mem_out_d;
            sram_addr_q <= sram_addr_d;
            sram_we_n_q <= sram_we_n_d;
            dq_out_q    <= dq_out_d;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            align_err_q <= align_err_d;
`endif
        end
    end

    assign ready      = (state_q == S_DONE) | ((state_q == S_IDLE) & ~req);
    assign Freeze_Out = req & ~ready;
    assign Mem_Out    = mem_out_q;
    assign SRAM_ADDR  = sram_addr_q;
    assign SRAM_WE_N  = sram_we_n_q;
    assign SRAM_DQ    = sram_we_n_q ? 16'bz : dq_out_q;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign Align_Err  = align_err_q;
`endif

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: async SRAM model plus per-cycle expected-pin scoreboard.
// Latency: each access is checked cycle by cycle over its 6-cycle window (WAIT_CYCLES=1).
// Backpressure: Freeze_Out/ready are part of every per-cycle expectation.
module tb_mem_stage_sram;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_result;
    logic [31:0] val_rm;
    logic [31:0] mem_out;
    logic        ready;
    logic        freeze_out;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_we_n;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] sram_mem [0:63];
    logic [15:0] ref_mem  [0:63];
    logic [31:0] ref_mo;

    typedef struct {
        logic [17:0] addr;
        logic        we_n;
        logic        dq_chk;
        logic [15:0] dq;
        logic        rdy;
        logic        frz;
        logic        mo_chk;
        logic [31:0] mo;
    } exp_t;

    exp_t sb [$];

    mem_stage_sram dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (mem_r_en),
        .MEM_W_EN   (mem_w_en),
        .ALU_Result (alu_result),
        .Val_Rm     (val_rm),
        .Mem_Out    (mem_out),
        .ready      (ready),
        .Freeze_Out (freeze_out),
        .SRAM_ADDR  (sram_addr),
        .SRAM_DQ    (sram_dq),
        .SRAM_WE_N  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async SRAM: output enable tied active, so it drives whenever WE_N is high.
    assign sram_dq = sram_we_n ? sram_mem[sram_addr[5:0]] : 16'bz;
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr[5:0]] <= sram_dq;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input logic [31:0] exp_mo);
        check({tag, "_we_n"}, 32'(sram_we_n), 32'd1);
        check({tag, "_addr"}, 32'(sram_addr), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_freeze"}, 32'(freeze_out), 32'd0);
        check({tag, "_memout"}, mem_out, exp_mo);
    endtask

    // Drive one request at cycle 0, push its 6-cycle expected trace, then compare ncyc cycles.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input bit flush, input int ncyc);
        logic [31:0] off;
        int          wi;
        exp_t        e;
        logic [31:0] mo_next;
        off = a - 32'd1024;
        wi  = int'(off[7:2]);
        mo_next = wr ? ref_mo : {ref_mem[2*wi+1], ref_mem[2*wi]};
        mem_r_en   = rd;
        mem_w_en   = wr;
        alu_result = a;
        val_rm     = d;
        for (int c = 0; c < 6; c++) begin
            e.addr   = (c == 1 || c == 2) ? 18'(2*wi) : (c == 3 || c == 4) ? 18'(2*wi+1) : 18'd0;
            e.dq_chk = wr && (c >= 1) && (c <= 4);
            e.we_n   = !e.dq_chk;
            e.dq     = (c <= 2) ? d[15:0] : d[31:16];
            e.rdy    = (c == 5);
            e.frz    = (c <= 1 || !flush) && (c != 5);
            e.mo_chk = (c == 5);
            e.mo     = mo_next;
            sb.push_back(e);
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("addr_c%0d", c), 32'(sram_addr), 32'(e.addr));
            check($sformatf("we_n_c%0d", c), 32'(sram_we_n), 32'(e.we_n));
            check($sformatf("ready_c%0d", c), 32'(ready), 32'(e.rdy));
            check($sformatf("freeze_c%0d", c), 32'(freeze_out), 32'(e.frz));
            if (e.dq_chk) check($sformatf("dq_c%0d", c), 32'(sram_dq), 32'(e.dq));
            if (e.mo_chk) check("mem_out_done", mem_out, e.mo);
            if (flush && c == 1) begin
                mem_r_en = 1'b0;
                mem_w_en = 1'b0;
            end
        end
        sb.delete();
        if (ncyc == 6) begin
            ref_mo = mo_next;
            if (wr) begin
                ref_mem[2*wi]   = d[15:0];
                ref_mem[2*wi+1] = d[31:16];
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = 16'hA000 + 16'(i);
            ref_mem[i]  = 16'hA000 + 16'(i);
        end
        ref_mo     = 32'd0;
        rst        = 1'b1;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        alu_result = 32'd0;
        val_rm     = 32'd0;
        @(negedge clk);
        check_idle("reset", 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("post_reset", 32'd0);
        @(posedge clk);
        #1;

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 6);   // store
        access(1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 6);   // load back
        access(1'b1, 1'b0, 32'd1028, 32'h0,        1'b0, 6);   // back-to-back load
        access(1'b0, 1'b1, 32'd1032, 32'h12345678, 1'b0, 6);   // then store
        access(1'b1, 1'b0, 32'd1032, 32'h0,        1'b0, 6);
        access(1'b1, 1'b1, 32'd1036, 32'hCAFEF00D, 1'b0, 6);   // both enables: write wins
        access(1'b1, 1'b0, 32'd1036, 32'h0,        1'b1, 6);   // flushed load still completes

        // Write to 1040 cut off by reset in the middle of its HIGH phase
        access(1'b0, 1'b1, 32'd1040, 32'h0BADF00D, 1'b0, 4);
        rst      = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        ref_mo   = 32'd0;
        @(negedge clk);
        check_idle("rst_mid", 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("rst_rel", 32'd0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 6);

        // Random mix; word 4 is skipped because its content is undefined after the cut write
        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            logic        op;
            a  = 32'd1024 + 32'(4 * $urandom_range(5, 31)) + 32'($urandom_range(0, 3));
            op = 1'($urandom_range(0, 1));
            access(!op, op, a, $urandom, 1'b0, 6);
        end

        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        @(negedge clk);
        check_idle("final", ref_mo);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
